// File: rtl/izh_if.sv
// izh_if: control/data bundle between a driver and the izh_update neuron core
interface izh_if #(parameter int N = 24);
  logic         start;
  logic         load;
  logic [N-1:0] v_load;
  logic [N-1:0] w_load;
  logic [N-1:0] i_in;
  logic [N-1:0] step;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] c;
  logic [N-1:0] d;
  logic [N-1:0] v;
  logic [N-1:0] w;
  logic         spike;
  logic         done;
  logic         busy;
  modport master (
    output start, load, v_load, w_load, i_in, step, a, b, c, d,
    input  v, w, spike, done, busy
  );
  modport slave (
    input  start, load, v_load, w_load, i_in, step, a, b, c, d,
    output v, w, spike, done, busy
  );
endinterface

// File: rtl/izh_update.sv
// izh_update: one Izhikevich Euler step per start, sequenced over a single shared
// fixed-point multiplier.
module izh_update #(
  parameter int N = 24,
  parameter int Q = 8
) (
  input logic  clk,
  input logic  rst_n,
  izh_if.slave bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] VV     = 3'd1;
  localparam logic [2:0] K04    = 3'd2;
  localparam logic [2:0] DV     = 3'd3;
  localparam logic [2:0] BV     = 3'd4;
  localparam logic [2:0] AW     = 3'd5;
  localparam logic [2:0] WS     = 3'd6;
  localparam logic [2:0] COMMIT = 3'd7;
  localparam logic signed [N-1:0] KC    = N'(10);
  localparam logic signed [N-1:0] C140  = N'(140 << Q);
  localparam logic signed [N-1:0] VTH   = N'(30 << Q);
  localparam logic signed [N-1:0] V_RST = N'(-65 << Q);
  localparam logic signed [N-1:0] W_RST = N'(-13 << Q);
  logic [2:0] state;
  logic signed [N-1:0] vq, wq, ir, stepr, ar, br, cr, dr;
  logic signed [N-1:0] t, dv, p, qa, dw;
  logic signed [N-1:0] ma, mb, sum, mres, vn, wn;
  logic signed [2*N-1:0] prod;
  logic spk;
  // 5*v is built from a shift and add so the multiplier stays free for t*K
  always_comb begin
    sum  = t + (vq <<< 2) + vq + C140 - wq + ir;
    ma   = state == VV ? vq : state == K04 ? KC : state == DV ? sum :
           state == BV ? br : state == AW ? ar : qa;
    mb   = state == VV ? vq : state == K04 ? t : state == DV ? stepr :
           state == BV ? vq : state == AW ? p - wq : stepr;
    prod = ma * mb;
    mres = prod[N+Q-1:Q];
    vn   = vq + dv;
    wn   = wq + dw;
    spk  = vn >= VTH;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vq        <= V_RST;
      wq        <= W_RST;
      bus.spike <= 1'b0;
      bus.done  <= 1'b0;
      ir        <= '0;
      stepr     <= '0;
      ar        <= '0;
      br        <= '0;
      cr        <= '0;
      dr        <= '0;
      t         <= '0;
      dv        <= '0;
      p         <= '0;
      qa        <= '0;
      dw        <= '0;
    end else begin
      bus.done  <= state == COMMIT;
      bus.spike <= state == COMMIT && spk;
      if (state == IDLE) begin
        if (bus.load) begin
          vq <= bus.v_load;
          wq <= bus.w_load;
        end else if (bus.start) begin
          ir    <= bus.i_in;
          stepr <= bus.step;
          ar    <= bus.a;
          br    <= bus.b;
          cr    <= bus.c;
          dr    <= bus.d;
          state <= VV;
        end
      end else begin
        state <= state == COMMIT ? IDLE : state + 3'd1;
      end
      if (state == VV || state == K04) t <= mres;
      if (state == DV) dv <= mres;
      if (state == BV) p <= mres;
      if (state == AW) qa <= mres;
      if (state == WS) dw <= mres;
      if (state == COMMIT) begin
        vq <= spk ? cr : vn;
        wq <= spk ? wn + dr : wn;
      end
    end
  end
  assign bus.v    = vq;
  assign bus.w    = wq;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_izh_update.sv
// tb_izh_update: directed-vector bench for izh_update with hand-computed expectations.
module tb_izh_update;
  localparam int N = 24;
  localparam int Q = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  izh_if #(.N(N)) bus ();
  izh_update #(.N(N), .Q(Q)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask
  task automatic do_load(input logic [N-1:0] lv, input logic [N-1:0] lw);
    @(negedge clk);
    bus.load = 1'b1;
    bus.v_load = lv;
    bus.w_load = lw;
    @(negedge clk);
    bus.load = 1'b0;
    chk("load_v", bus.v, lv);
    chk("load_w", bus.w, lw);
  endtask
  // Issues one start, scrambles the inputs after accept, and checks busy/done timing;
  // returns #1 after the COMMIT edge, in the done cycle.
  task automatic run(input string tag, input logic [N-1:0] ii, input logic [N-1:0] ss,
                     input logic [N-1:0] aa, input logic [N-1:0] bb,
                     input logic [N-1:0] cc, input logic [N-1:0] dd);
    @(negedge clk);
    bus.i_in = ii;
    bus.step = ss;
    bus.a = aa;
    bus.b = bb;
    bus.c = cc;
    bus.d = dd;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.i_in = N'($urandom);
    bus.step = N'($urandom);
    bus.a = N'($urandom);
    bus.b = N'($urandom);
    bus.c = N'($urandom);
    bus.d = N'($urandom);
    chkb({tag, "_busy0"}, bus.busy, 1'b1);
    chkb({tag, "_done0"}, bus.done, 1'b0);
    for (int k = 1; k < 7; k++) begin
      @(posedge clk);
      #1;
      chkb({tag, "_busy"}, bus.busy, 1'b1);
      chkb({tag, "_done_early"}, bus.done, 1'b0);
    end
    @(posedge clk);
    #1;
    chkb({tag, "_done"}, bus.done, 1'b1);
    chkb({tag, "_busy_done"}, bus.busy, 1'b0);
  endtask
  initial begin
    int nd;
    bus.start = 1'b0;
    bus.load = 1'b0;
    bus.v_load = '0;
    bus.w_load = '0;
    bus.i_in = '0;
    bus.step = '0;
    bus.a = '0;
    bus.b = '0;
    bus.c = '0;
    bus.d = '0;
    #12 rst_n = 1'b1;
    do_load(24'h001234, 24'h000567);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_v", bus.v, 24'hFFBF00);
    chk("rst_w", bus.w, 24'hFFF300);
    chkb("rst_spike", bus.spike, 1'b0);
    chkb("rst_done", bus.done, 1'b0);
    chkb("rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run("lat", 24'h0, 24'h0, 24'h000005, 24'h000033, 24'h0, 24'h0);
    chk("lat_v", bus.v, 24'hFFBF00);
    chk("lat_w", bus.w, 24'hFFF300);
    chkb("lat_spike", bus.spike, 1'b0);
    @(posedge clk);
    #1;
    chkb("lat_done_1cyc", bus.done, 1'b0);
    run("sub1", 24'h0, 24'h000100, 24'h000005, 24'h000033, 24'hFFBF00, 24'h000800);
    chk("sub1_v", bus.v, 24'hFFB80A);
    chk("sub1_w", bus.w, 24'hFFF300);
    chkb("sub1_spike", bus.spike, 1'b0);
    run("sub2", 24'h0, 24'h000100, 24'h000005, 24'h000033, 24'hFFBF00, 24'h000800);
    chk("sub2_v", bus.v, 24'hFFB383);
    chk("sub2_w", bus.w, 24'hFFF2F9);
    chkb("sub2_spike", bus.spike, 1'b0);
    do_load(24'h001D00, 24'h000000);
    run("spk", 24'h0, 24'h000100, 24'h0, 24'h0, 24'hFFBF00, 24'h000800);
    chk("spk_v", bus.v, 24'hFFBF00);
    chk("spk_w", bus.w, 24'h000800);
    chkb("spk_spike", bus.spike, 1'b1);
    @(posedge clk);
    #1;
    chkb("spk_spike_1cyc", bus.spike, 1'b0);
    chkb("spk_done_1cyc", bus.done, 1'b0);
    do_load(24'h000A00, 24'h000100);
    @(negedge clk);
    bus.step = '0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    nd = 0;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      bus.start = (k == 2 || k == 5);
      bus.load = (k == 3 || k == 5);
      bus.v_load = 24'h123456;
      bus.w_load = 24'h654321;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.load = 1'b0;
      nd += int'(bus.done);
    end
    chk("blk_ndone", N'(nd), 24'd1);
    chk("blk_v", bus.v, 24'h000A00);
    chk("blk_w", bus.w, 24'h000100);
    @(negedge clk);
    bus.load = 1'b1;
    bus.start = 1'b1;
    bus.v_load = 24'h000300;
    bus.w_load = 24'hFFFF00;
    bus.step = 24'h000100;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    bus.start = 1'b0;
    chk("ls_v", bus.v, 24'h000300);
    chk("ls_w", bus.w, 24'hFFFF00);
    chkb("ls_busy", bus.busy, 1'b0);
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      nd += int'(bus.done);
    end
    chk("ls_ndone", N'(nd), 24'd0);
    do_load(24'h001D00, 24'h000000);
    @(negedge clk);
    bus.i_in = '0;
    bus.step = 24'h000100;
    bus.a = '0;
    bus.b = '0;
    bus.c = 24'hFFBF00;
    bus.d = 24'h000800;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_v", bus.v, 24'hFFBF00);
    chk("mid_w", bus.w, 24'hFFF300);
    chkb("mid_busy", bus.busy, 1'b0);
    chkb("mid_done", bus.done, 1'b0);
    chkb("mid_spike", bus.spike, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      nd += int'(bus.done) + int'(bus.spike);
    end
    chk("mid_ndone", N'(nd), 24'd0);
    chk("mid_w_hold", bus.w, 24'hFFF300);
    run("post", 24'h0, 24'h000100, 24'h000005, 24'h000033, 24'h0, 24'h0);
    chk("post_v", bus.v, 24'hFFB80A);
    chk("post_w", bus.w, 24'hFFF300);
    chkb("post_spike", bus.spike, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
